radix2_divider: RTL

RADIX2_DIVIDER -- requirements
Module: radix2_divider

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 24 ++
 rtl/radix2_divider.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_pkg: FSM state encoding and default width for radix2_divider.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_step: one combinational restoring-division iteration.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);

   logic [WIDTH:0] w_partial;

   assign w_partial = {rem_i, bit_i};
   assign qbit_o    = (w_partial >= {1'b0, divisor_i});
   // Low bits of the wide difference equal the modular narrow difference.
   assign rem_o     = qbit_o ? (w_partial[WIDTH-1:0] - divisor_i) : w_partial[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/radix2_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | radix2_divider: multi-cycle restoring 2W/W unsigned divider with   |
// | valid/ready handshakes. RADIX2_DIV_OVF_DETECT_EN enables overflow   |
// | detection on accept.                                               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module radix2_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_zero,
   output logic               ovf
);

   localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] w_step_rem;
   logic             w_qbit;
`ifdef RADIX2_DIV_OVF_DETECT_EN
   logic             ovf_q, ovf_d;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .bit_i     (lo_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (w_step_rem),
      .qbit_o    (w_qbit)
   );

   // lo_q shifts dividend bits out at the top while quotient bits enter at the bottom.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      lo_d    = lo_q;
      dvs_d   = dvs_q;
      dz_d    = dz_q;
`ifdef RADIX2_DIV_OVF_DETECT_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               dvs_d = divisor;
               cnt_d = '0;
               dz_d  = 1'b0;
`ifdef RADIX2_DIV_OVF_DETECT_EN
               ovf_d = 1'b0;
`endif
               if (divisor == '0) begin
                  state_d = ST_DONE;
                  lo_d    = '1;
                  rem_d   = dividend[WIDTH-1:0];
                  dz_d    = 1'b1;
               end
`ifdef RADIX2_DIV_OVF_DETECT_EN
               else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                  state_d = ST_DONE;
                  lo_d    = '1;
                  rem_d   = dividend[WIDTH-1:0];
                  ovf_d   = 1'b1;
               end
`endif
               else begin
                  state_d = ST_CALC;
                  rem_d   = dividend[2*WIDTH-1:WIDTH];
                  lo_d    = dividend[WIDTH-1:0];
               end
            end
         end
         ST_CALC: begin
            rem_d = w_step_rem;
            lo_d  = {lo_q[WIDTH-2:0], w_qbit};
            if (cnt_q == C_CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         lo_q    <= '0;
         dvs_q   <= '0;
         dz_q    <= 1'b0;
`ifdef RADIX2_DIV_OVF_DETECT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         lo_q    <= lo_d;
         dvs_q   <= dvs_d;
         dz_q    <= dz_d;
`ifdef RADIX2_DIV_OVF_DETECT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign quotient  = lo_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;
`ifdef RADIX2_DIV_OVF_DETECT_EN
   assign ovf       = ovf_q;
`else
   assign ovf       = 1'b0;
`endif

endmodule
`default_nettype wire
